// File: rtl/ssm4_fu.sv
// ssm4_fu: scalar SM4 functional unit for ssm4.ed (round) and ssm4.ks (key schedule).
// Build option SSM4_FU_PIPE_EN: when defined, an S1 register separates the S-box from the
// linear layer (2-cycle latency). When undefined, the S-box feeds the output register
// directly (1-cycle latency). Results are identical in both builds.
module ssm4_fu (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op_ed,
    input  logic        req_op_ks,
    input  logic [1:0]  req_bs,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
        8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
        8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
        8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
        8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
        8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
        8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
        8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
        8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
        8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
        8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
        8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
        8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
        8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
        8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
        8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
        8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Linear layer, byte rotate and rs1 mix; a malformed op or a write to x0 yields zero.
    function automatic logic [31:0] sm4_mix(input logic [7:0] s, input logic ed,
                                            input logic [1:0] bs, input logic [31:0] rs1,
                                            input logic [4:0] rd, input logic err);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        x = {24'h0, s};
        if (ed) begin
            y = x ^ (x << 8) ^ (x << 2) ^ (x << 18) ^ ((x & 32'h3F) << 26) ^
                ((x & 32'hC0) << 10);
        end else begin
            y = x ^ ((x & 32'h07) << 29) ^ ((x & 32'hFE) << 7) ^ ((x & 32'h01) << 23) ^
                ((x & 32'hF8) << 13);
        end
        case (bs)
            2'd0:    z = y;
            2'd1:    z = {y[23:0], y[31:24]};
            2'd2:    z = {y[15:0], y[31:16]};
            default: z = {y[7:0], y[31:8]};
        endcase
        if (err || rd == 5'd0) begin
            return 32'h0;
        end
        return z ^ rs1;
    endfunction

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic        rsp_err_q, rsp_err_d;

    logic        s2_load;
    logic        req_fire;
    logic        req_err;
    logic [7:0]  req_sbox;

    // Operands presented to the output register.
    logic        src_valid;
    logic [7:0]  src_sbox;
    logic [31:0] src_rs1;
    logic [1:0]  src_bs;
    logic        src_ed;
    logic [4:0]  src_rd;
    logic        src_err;

    assign s2_load  = !rsp_valid_q || rsp_ready;
    assign req_fire = req_valid && req_ready;
    assign req_err  = (req_op_ed == req_op_ks);
    assign req_sbox = SBOX[req_rs2[{req_bs, 3'b000} +: 8]];

`ifdef SSM4_FU_PIPE_EN
    logic        s1_valid_q, s1_valid_d;
    logic [7:0]  s1_sbox_q, s1_sbox_d;
    logic [31:0] s1_rs1_q, s1_rs1_d;
    logic [1:0]  s1_bs_q, s1_bs_d;
    logic        s1_ed_q, s1_ed_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic        s1_err_q, s1_err_d;
    logic        s1_load;

    // S1 is free when empty or when its contents move into S2 this edge.
    assign s1_load   = !s1_valid_q || s2_load;
    assign req_ready = s1_load && !flush && g_resetn;

    // S1 next state: capture the S-box byte and the operands it travels with.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sbox_d  = s1_sbox_q;
        s1_rs1_d   = s1_rs1_q;
        s1_bs_d    = s1_bs_q;
        s1_ed_d    = s1_ed_q;
        s1_rd_d    = s1_rd_q;
        s1_err_d   = s1_err_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_load) begin
            s1_valid_d = req_fire;
            if (req_fire) begin
                s1_sbox_d = req_sbox;
                s1_rs1_d  = req_rs1;
                s1_bs_d   = req_bs;
                s1_ed_d   = req_op_ed;
                s1_rd_d   = req_rd;
                s1_err_d  = req_err;
            end
        end
    end

    // S1 state with synchronous reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            s1_valid_q <= 1'b0;
            s1_sbox_q  <= 8'h0;
            s1_rs1_q   <= 32'h0;
            s1_bs_q    <= 2'd0;
            s1_ed_q    <= 1'b0;
            s1_rd_q    <= 5'd0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sbox_q  <= s1_sbox_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_bs_q    <= s1_bs_d;
            s1_ed_q    <= s1_ed_d;
            s1_rd_q    <= s1_rd_d;
            s1_err_q   <= s1_err_d;
        end
    end

    assign src_valid = s1_valid_q;
    assign src_sbox  = s1_sbox_q;
    assign src_rs1   = s1_rs1_q;
    assign src_bs    = s1_bs_q;
    assign src_ed    = s1_ed_q;
    assign src_rd    = s1_rd_q;
    assign src_err   = s1_err_q;
`else
    assign req_ready = s2_load && !flush && g_resetn;

    assign src_valid = req_fire;
    assign src_sbox  = req_sbox;
    assign src_rs1   = req_rs1;
    assign src_bs    = req_bs;
    assign src_ed    = req_op_ed;
    assign src_rd    = req_rd;
    assign src_err   = req_err;
`endif

    // S2 next state: flush wins over drain; data only changes when a new result loads.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_err_d    = rsp_err_q;
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (s2_load) begin
            rsp_valid_d = src_valid;
            if (src_valid) begin
                rsp_result_d = sm4_mix(src_sbox, src_ed, src_bs, src_rs1, src_rd, src_err);
                rsp_rd_d     = src_rd;
                rsp_err_d    = src_err;
            end
        end
    end

    // S2 output register with synchronous reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 32'h0;
            rsp_rd_q     <= 5'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_rd     = rsp_rd_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: doc/ssm4_fu.md
# ssm4_fu

Pipelined functional unit executing the scalar SM4 instructions `ssm4.ed` (encrypt/decrypt round) and `ssm4.ks` (key schedule) for the SCARV core execute stage. It takes operands and a byte-select immediate through a valid/ready request port. It returns the destination-register write value through a valid/ready response port that supports backpressure and pipeline flush. Results are exactly those required by the formal SM4 instruction checker, including forcing writes to `x0` to zero.

## Interface
No parameters; all widths fixed (XLEN=32).
- `g_clk` in 1: clock, all state on rising edge.
- `g_resetn` in 1: synchronous, active-low reset.
- `flush` in 1: discard all in-flight operations.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit accepts request this cycle.
- `req_op_ed` in 1: select `ssm4.ed`.
- `req_op_ks` in 1: select `ssm4.ks`.
- `req_bs` in 2: byte select, insn[31:30].
- `req_rs1` in 32: source register 1 value.
- `req_rs2` in 32: source register 2 value.
- `req_rd` in 5: destination register address, carried as tag.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer takes result.
- `rsp_result` out 32: rd write data.
- `rsp_rd` out 5: tag echoed from request.
- `rsp_err` out 1: request had neither or both op selects.

## Operation
- Accept when `req_valid && req_ready`.
- x = sbox(`req_rs2` byte `req_bs`), zero-extended to 32 bits. SM4 S-box, 256-entry constant.
- ED: y = x ^ x<<8 ^ x<<2 ^ x<<18 ^ (x&0x3F)<<26 ^ (x&0xC0)<<10.
- KS: y = x ^ (x&0x07)<<29 ^ (x&0xFE)<<7 ^ (x&0x01)<<23 ^ (x&0xF8)<<13.
- All shifts are 32-bit and truncating.
- z = rol32(y, 8*bs); result = z ^ rs1.
- `rd`==0 → `rsp_result`=0.
- `rsp_err`=1 and `rsp_result`=0 if `req_op_ed`==`req_op_ks`. The request is still accepted and a response is still produced.
- Stage S1 (pipelined build only) registers rs1, bs, op, rd, err and the S-box output byte.
- Output register S2 computes the linear layer, rotate and XOR on load.
- S2 loads when `!rsp_valid || rsp_ready`.
- S1 loads when S1 is empty or S1 advances into S2.
- `req_ready` = S1 load condition && `!flush`. It is combinational from `rsp_ready`; no skid buffer.
- Ordering is strictly in-order; there is no reordering or combining.

## Timing
- Reset (`g_resetn`=0 at an edge): S1 valid=0, `rsp_valid`=0, `rsp_result`=0, `rsp_rd`=0, `rsp_err`=0.
- During reset `req_ready`=0.
- Latency, pipelined: request accepted at edge N → `rsp_valid`=1 after edge N+1. With the macro undefined: after edge N.
- Throughput is one per cycle while `rsp_ready`=1.
- `rsp_valid` held high: `rsp_result`, `rsp_rd` and `rsp_err` stay stable until the edge where `rsp_ready`=1.
- Simultaneous response drain and new S2 load in the same edge is allowed and gives no bubble.
- `rsp_ready`=0 with S1 and S2 full: `req_ready`=0 and there is no data loss.
- `flush`=1 at an edge: S1 valid and `rsp_valid` are cleared next cycle; any request in that cycle is not accepted.
- `flush` has priority over a simultaneous `rsp_ready` handshake. The consumer ignores a response during a flush cycle.
- Reset mid-operation discards everything; data registers are zeroed.

## Configuration
- `SSM4_FU_PIPE_EN` defined: S1 is present; latency is 2 cycles; the S-box is isolated from the linear layer for timing.
- `SSM4_FU_PIPE_EN` undefined: S1 is removed and the S-box plus linear layer feed S2 directly; latency is 1 cycle.
- Undefined build: `req_ready` = (`!rsp_valid || rsp_ready`) && `!flush`.
- All functional results are identical in both builds.

## Test plan
- ED, rs1=0, rs2=0, bs=0, rd=5 → `rsp_result`=0x5B5BD58E, `rsp_rd`=5, `rsp_err`=0, 2 cycles after accept (1 without macro).
- ED, rs1=0xFFFFFFFF, rs2=0, bs=1, rd=1 → 0x5BD58E5B ^ 0xFFFFFFFF = 0xA42A71A4.
- KS, rs1=0, rs2=0, bs=0, rd=3 → 0xC01A6BD6. The same operation with rd=0 → 0x00000000.
- Backpressure: 4 back-to-back ED requests with `rsp_ready` held 0 for 5 cycles.
  - `req_ready` drops after 2 accepts (1 without macro).
  - All 4 results then drain in order with no loss or duplication.
  - `rsp_result` stays stable while stalled.
- Flush with S1 and S2 full and a request present → next cycle `rsp_valid`=0 and S1 empty; the flush-cycle request is not accepted, and a following request completes normally.
- Error and reset: `req_op_ed`=`req_op_ks`=1 → `rsp_err`=1 with result 0. `g_resetn`=0 asserted mid-stream → all outputs 0 after the edge and `req_ready`=0 while held.
